// File: rtl/control_step_sequencer_if.sv
// control_step_sequencer_if: control-unit handshake and fetch-strobe bundle of the step sequencer
interface control_step_sequencer_if #(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 3
);
    logic                 run_i, stop_i, end_i, mem_ready_i;
    logic [STEP_W-1:0]    step_o;
    logic [NUM_STEPS-1:0] t_o;
    logic                 running_o, fault_o;
    logic                 pc_out_o, mar_in_o, inc_pc_o, zlow_in_o, zlow_out_o;
    logic                 pc_in_o, read_o, mdr_in_o, mdr_out_o, ir_in_o;
    modport slave (
        input  run_i, stop_i, end_i, mem_ready_i,
        output step_o, t_o, running_o, fault_o,
               pc_out_o, mar_in_o, inc_pc_o, zlow_in_o, zlow_out_o,
               pc_in_o, read_o, mdr_in_o, mdr_out_o, ir_in_o
    );
    modport master (
        output run_i, stop_i, end_i, mem_ready_i,
        input  step_o, t_o, running_o, fault_o,
               pc_out_o, mar_in_o, inc_pc_o, zlow_in_o, zlow_out_o,
               pc_in_o, read_o, mdr_in_o, mdr_out_o, ir_in_o
    );
endinterface

// File: rtl/control_step_sequencer.sv
// control_step_sequencer: one-hot T-step generator with fetch-phase strobes, memory wait, overrun fault and halt
module control_step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    control_step_sequencer_if.slave   b
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HALT = 2'd3;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              pend_q, pend_d, fault_q, fault_d, wrap;
    logic              act, t0, t1, t2;

    // next state: start/resume, T1 memory wait, End restart, overrun wrap, halt at instruction boundary
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pend_d  = pend_q;
        fault_d = 1'b0;
        wrap    = 1'b0;
        if (state_q == IDLE || state_q == HALT) begin
            if (b.run_i && !b.stop_i) begin
                state_d = RUN;
                step_d  = '0;
            end
        end else begin
            pend_d = pend_q | b.stop_i;
            if (state_q == WAIT || step_q == STEP_W'(1)) begin
                state_d = b.mem_ready_i ? RUN : WAIT;
                step_d  = b.mem_ready_i ? STEP_W'(2) : STEP_W'(1);
            end else if (step_q >= STEP_W'(3) && b.end_i) begin
                wrap = 1'b1;
            end else if (step_q == LAST) begin
                wrap    = 1'b1;
                fault_d = 1'b1;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
            if (wrap) begin
                step_d  = '0;
                state_d = pend_d ? HALT : RUN;
                pend_d  = 1'b0;
            end
        end
    end

    // state registers; clear abandons any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
        end
    end

    // output decode of registered step; only T1 looks at MemReady
    always_comb begin
        act          = state_q == RUN || state_q == WAIT;
        t0           = act && step_q == STEP_W'(0);
        t1           = act && step_q == STEP_W'(1);
        t2           = act && step_q == STEP_W'(2);
        b.step_o     = act ? step_q : '0;
        b.t_o        = act ? NUM_STEPS'(1) << step_q : '0;
        b.running_o  = act;
        b.fault_o    = fault_q;
        b.pc_out_o   = t0;
        b.mar_in_o   = t0;
        b.inc_pc_o   = t0;
        b.zlow_in_o  = t0;
        b.read_o     = t1;
        b.mdr_in_o   = t1;
        b.zlow_out_o = t1 && b.mem_ready_i;
        b.pc_in_o    = t1 && b.mem_ready_i;
        b.mdr_out_o  = t2;
        b.ir_in_o    = t2;
    end
endmodule
